// File: rtl/bp_me_pkg.sv
// Shared types for the BlackParrot coherence-link repeater.
//   bp_coh_link_state_e : input-side packet tracker states
//   `BP_COH_LINK_HDR_S  : header-flit field view {len, cord}, widths by macro args
`ifndef BP_ME_PKG_HDR_GUARD
`define BP_ME_PKG_HDR_GUARD
`define BP_COH_LINK_HDR_S(cord_w, len_w) \
  struct packed {                          \
    logic [(len_w)-1:0]  len;              \
    logic [(cord_w)-1:0] cord;             \
  }
`endif

package bp_me_pkg;

  localparam int unsigned coh_noc_flit_width_p = 32;

  typedef enum logic [1:0] {
    eIdle     = 2'd0,
    eBody     = 2'd1,
    eQuiesced = 2'd2
  } bp_coh_link_state_e;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO with valid/ready on the write side and valid/yumi on the read side.
//   clk_i, reset_i   : clock, async active-high reset
//   data_i, v_i      : write data / write request (ignored when full)
//   ready_o          : FIFO not full
//   data_o, v_o      : head entry / FIFO not empty
//   yumi_i           : consumer takes the head this cycle
module bsg_two_fifo #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;
  logic               push;
  logic               pop;

  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;
  assign ready_o = (count != 2'd2);
  assign v_o     = (count != 2'd0);
  assign data_o  = mem[rd_ptr];

  // Pointers and occupancy
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/bp_coh_link_quiesce_repeater.sv
// One-direction registered repeater for a coherence-network link between stacked pods.
// Tracks wormhole packet boundaries so the link can be closed only between packets.
//   bp_clk_i, bp_reset_i           : clock, async active-high reset
//   in_data_i, in_v_i, in_ready_and_o   : upstream flit handshake
//   out_data_o, out_v_o, out_ready_and_i: downstream flit handshake
//   quiesce_i                      : stop admitting new packets
//   quiesced_o                     : closed and drained
//   pkt_count_o                    : packets fully accepted on the input (wrapping)
module bp_coh_link_quiesce_repeater
  import bp_me_pkg::*;
#(
  parameter int unsigned flit_width_p  = coh_noc_flit_width_p,
  parameter int unsigned cord_width_p  = 7,
  parameter int unsigned len_width_p   = 5,
  parameter int unsigned count_width_p = 16
) (
  input  logic                     bp_clk_i,
  input  logic                     bp_reset_i,
  input  logic [flit_width_p-1:0]  in_data_i,
  input  logic                     in_v_i,
  output logic                     in_ready_and_o,
  output logic [flit_width_p-1:0]  out_data_o,
  output logic                     out_v_o,
  input  logic                     out_ready_and_i,
  input  logic                     quiesce_i,
  output logic                     quiesced_o,
  output logic [count_width_p-1:0] pkt_count_o
);

  localparam int unsigned hdr_width_lp = cord_width_p + len_width_p;

  typedef `BP_COH_LINK_HDR_S(cord_width_p, len_width_p) hdr_s;

  function automatic logic [len_width_p-1:0] hdr_len(input hdr_s h);
    return h.len;
  endfunction

  bp_coh_link_state_e     state;
  logic [len_width_p-1:0] rem;
  logic [len_width_p-1:0] len_li;
  logic                   fifo_ready;
  logic                   in_fire;

  assign len_li  = hdr_len(hdr_s'(in_data_i[hdr_width_lp-1:0]));

  // Ready depends only on registered state, FIFO fullness and reset
  assign in_ready_and_o = (state != eQuiesced) && fifo_ready && !bp_reset_i;
  assign in_fire        = in_v_i && in_ready_and_o;
  assign quiesced_o     = (state == eQuiesced) && !out_v_o;

  bsg_two_fifo #(
    .width_p(flit_width_p)
  ) buffer (
    .clk_i  (bp_clk_i),
    .reset_i(bp_reset_i),
    .data_i (in_data_i),
    .v_i    (in_fire),
    .ready_o(fifo_ready),
    .data_o (out_data_o),
    .v_o    (out_v_o),
    .yumi_i (out_ready_and_i)
  );

  // Packet-boundary tracker: quiesce closes only in eIdle or at the last body flit
  always_ff @(posedge bp_clk_i or posedge bp_reset_i) begin
    if (bp_reset_i) begin
      state       <= eIdle;
      rem         <= '0;
      pkt_count_o <= '0;
    end else begin
      case (state)
        eIdle: begin
          if (in_fire) begin
            if (len_li == '0) begin
              pkt_count_o <= pkt_count_o + count_width_p'(1);
            end else begin
              rem   <= len_li;
              state <= eBody;
            end
          end else if (quiesce_i) begin
            state <= eQuiesced;
          end
        end
        eBody: begin
          if (in_fire) begin
            rem <= rem - len_width_p'(1);
            if (rem == len_width_p'(1)) begin
              pkt_count_o <= pkt_count_o + count_width_p'(1);
              state       <= quiesce_i ? eQuiesced : eIdle;
            end
          end
        end
        eQuiesced: begin
          if (!quiesce_i) state <= eIdle;
        end
        default: state <= eIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_coh_link_quiesce_repeater.sv
module tb_bp_coh_link_quiesce_repeater;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_v;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_v;
  logic        out_ready;
  logic        quiesce;
  logic        quiesced;
  logic [15:0] pkt_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bp_coh_link_quiesce_repeater dut (
    .bp_clk_i       (clk),
    .bp_reset_i     (rst),
    .in_data_i      (in_data),
    .in_v_i         (in_v),
    .in_ready_and_o (in_ready),
    .out_data_o     (out_data),
    .out_v_o        (out_v),
    .out_ready_and_i(out_ready),
    .quiesce_i      (quiesce),
    .quiesced_o     (quiesced),
    .pkt_count_o    (pkt_count)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        ordy;
    logic        q;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_qd;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  // Header flit: tag in upper bits, len at [11:7], cord at [6:0]
  function automatic logic [31:0] hdr(input int len, input int tag);
    return (32'(tag) << 12) | (32'(len) << 7) | 32'h11;
  endfunction

  function automatic logic [31:0] body(input int tag);
    return 32'hB0D0_0000 | 32'(tag);
  endfunction

  task automatic add(input logic v, input logic [31:0] d, input logic ordy, input logic q,
                     input logic e_ir, input logic e_ov, input logic [31:0] e_od,
                     input logic e_qd, input logic [15:0] e_cnt);
    vec_t r;
    r = '{v, d, ordy, q, e_ir, e_ov, e_od, e_qd, e_cnt};
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    logic [31:0] a0, b0, b1, b2, c0, c1, c2, c3, c4;
    logic [31:0] d0, d1, d2, d3, d4, e0, e1, e2, e3, f0;
    logic [31:0] g0, g1, j0, j1, j2, h0, h1, i0, w0;
    a0 = hdr(0, 1);  b0 = hdr(2, 2);  b1 = body(1);  b2 = body(2);
    c0 = hdr(4, 3);  c1 = body(3);    c2 = body(4);  c3 = body(5);  c4 = body(6);
    d0 = hdr(4, 4);  d1 = body(7);    d2 = body(8);  d3 = body(9);  d4 = body(10);
    e0 = hdr(3, 5);  e1 = body(11);   e2 = body(12); e3 = body(13); f0 = hdr(0, 6);
    g0 = hdr(1, 7);  g1 = body(14);
    j0 = hdr(2, 8);  j1 = body(15);   j2 = body(16);
    h0 = hdr(3, 9);  h1 = body(17);   i0 = hdr(0, 10); w0 = hdr(0, 11);

    // Streaming: len 0, 2, 4
    add(1, a0, 1, 0, 1, 0, 0,  0, 0);
    add(1, b0, 1, 0, 1, 1, a0, 0, 1);
    add(1, b1, 1, 0, 1, 1, b0, 0, 1);
    add(1, b2, 1, 0, 1, 1, b1, 0, 1);
    add(1, c0, 1, 0, 1, 1, b2, 0, 2);
    add(1, c1, 1, 0, 1, 1, c0, 0, 2);
    add(1, c2, 1, 0, 1, 1, c1, 0, 2);
    add(1, c3, 1, 0, 1, 1, c2, 0, 2);
    add(1, c4, 1, 0, 1, 1, c3, 0, 2);
    add(0, 0,  1, 0, 1, 1, c4, 0, 3);
    add(0, 0,  1, 0, 1, 0, 0,  0, 3);
    // Backpressure: 5 cycles stalled during a 4-body packet
    add(1, d0, 0, 0, 1, 1'b0, 0, 0, 3);
    add(1, d1, 0, 0, 1, 1, d0, 0, 3);
    add(1, d2, 0, 0, 0, 1, d0, 0, 3);
    add(1, d2, 0, 0, 0, 1, d0, 0, 3);
    add(1, d2, 0, 0, 0, 1, d0, 0, 3);
    add(1, d2, 1, 0, 0, 1, d0, 0, 3);
    add(1, d2, 1, 0, 1, 1, d1, 0, 3);
    add(1, d3, 1, 0, 1, 1, d2, 0, 3);
    add(1, d4, 1, 0, 1, 1, d3, 0, 3);
    add(0, 0,  1, 0, 1, 1, d4, 0, 4);
    add(0, 0,  1, 0, 1, 0, 0,  0, 4);
    // Mid-packet quiesce on a len=3 packet
    add(1, e0, 1, 0, 1, 0, 0,  0, 4);
    add(1, e1, 1, 0, 1, 1, e0, 0, 4);
    add(1, e2, 1, 1, 1, 1, e1, 0, 4);
    add(1, e3, 1, 1, 1, 1, e2, 0, 4);
    add(1, f0, 1, 1, 0, 1, e3, 0, 5);
    add(1, f0, 1, 1, 0, 0, 0,  1, 5);
    add(0, 0,  1, 0, 0, 0, 0,  1, 5);
    add(0, 0,  1, 0, 1, 0, 0,  0, 5);
    // Quiesce rising with a len=1 header
    add(1, g0, 1, 1, 1, 0, 0,  0, 5);
    add(1, g1, 1, 1, 1, 1, g0, 0, 5);
    add(0, 0,  1, 1, 0, 1, g1, 0, 6);
    add(0, 0,  1, 1, 0, 0, 0,  1, 6);
    add(0, 0,  1, 0, 0, 0, 0,  1, 6);
    add(0, 0,  1, 0, 1, 0, 0,  0, 6);
    // Quiesce while idle with no header
    add(0, 0,  1, 1, 1, 0, 0,  0, 6);
    add(0, 0,  1, 0, 0, 0, 0,  1, 6);
    add(0, 0,  1, 0, 1, 0, 0,  0, 6);
    // Quiesce dropped mid-packet: packet completes, link stays open
    add(1, j0, 1, 1, 1, 0, 0,  0, 6);
    add(1, j1, 1, 0, 1, 1, j0, 0, 6);
    add(1, j2, 1, 0, 1, 1, j1, 0, 6);
    add(0, 0,  1, 0, 1, 1, j2, 0, 7);
    add(0, 0,  1, 0, 1, 0, 0,  0, 7);

    rst = 1'b1; in_v = 1'b0; in_data = '0; out_ready = 1'b0; quiesce = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_v", 32'(out_v), 32'd0);
    chk("reset quiesced", 32'(quiesced), 32'd0);
    chk("reset pkt_count", 32'(pkt_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      in_v = tbl[i].v; in_data = tbl[i].d; out_ready = tbl[i].ordy; quiesce = tbl[i].q;
      #1;
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("row%0d out_v", i), 32'(out_v), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("row%0d out_data", i), out_data, tbl[i].e_od);
      chk($sformatf("row%0d quiesced", i), 32'(quiesced), 32'(tbl[i].e_qd));
      chk($sformatf("row%0d pkt_count", i), 32'(pkt_count), 32'(tbl[i].e_cnt));
      @(negedge clk);
    end

    // Reset between body flits of a len=3 packet
    in_v = 1'b1; in_data = h0; out_ready = 1'b1; quiesce = 1'b0;
    @(negedge clk);
    in_data = h1;
    @(negedge clk);
    in_v = 1'b0;
    #1;
    chk("pre-reset out_v", 32'(out_v), 32'd1);
    rst = 1'b1;
    #1;
    chk("midpkt reset out_v", 32'(out_v), 32'd0);
    chk("midpkt reset pkt_count", 32'(pkt_count), 32'd0);
    chk("midpkt reset in_ready", 32'(in_ready), 32'd0);
    chk("midpkt reset quiesced", 32'(quiesced), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", 32'(in_ready), 32'd1);
    in_v = 1'b1; in_data = i0;
    @(negedge clk);
    in_v = 1'b0;
    #1;
    chk("post-reset header out_v", 32'(out_v), 32'd1);
    chk("post-reset header out_data", out_data, i0);
    chk("post-reset header pkt_count", 32'(pkt_count), 32'd1);

    // Wrap: bring the counter to 65535 with len=0 packets, then one more
    in_v = 1'b1; in_data = w0;
    repeat (65534) @(negedge clk);
    in_v = 1'b0;
    #1;
    chk("wrap pre pkt_count", 32'(pkt_count), 32'hFFFF);
    in_v = 1'b1;
    @(negedge clk);
    in_v = 1'b0;
    #1;
    chk("wrap post pkt_count", 32'(pkt_count), 32'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
